// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int BUS_W   = 32;
  localparam int PC_W    = 32;
  localparam int PC_INCR = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [BUS_W-1:0] instr;
    logic [PC_W-1:0]  pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module   : instr_fifo
// Purpose  : Synchronous FIFO of fetched instructions with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !flush;
  assign w_do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage: one outstanding imem read, buffered for the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                  BUS_WIDTH  = BUS_W,
  parameter int                  PC_WIDTH   = PC_W,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  input  logic                 imem_rvalid,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic                 halt,
  output logic                 instr_valid,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]  instr_pc,
  input  logic                 next_instr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic               r_discard;
  logic               w_discard_next;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_room;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head_bits;
  fetch_entry_t       w_head;
  fetch_entry_t       w_wr_entry;

  // The in-flight request reserves a slot, so a response can always be pushed.
  assign w_room = (w_count + CNT_W'(r_state == WAIT)) < CNT_W'(FIFO_DEPTH);
  assign w_pop  = next_instr && !redirect_valid;

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_discard_next = r_discard;
    w_push         = 1'b0;
    imem_req       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!halt && !redirect_valid && w_room) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        imem_req     = 1'b1;
        w_pc_next    = r_pc + PC_WIDTH'(PC_INCR);
        w_state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_state_next   = IDLE;
          w_discard_next = 1'b0;
          w_push         = !r_discard && !redirect_valid && (!w_full || w_pop);
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A request already on the bus cannot be cancelled, only its data dropped.
    if (redirect_valid) begin
      w_pc_next = redirect_pc & ~PC_WIDTH'(3);
      if (r_state == REQ || (r_state == WAIT && !imem_rvalid)) begin
        w_discard_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= RESET_PC;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_discard <= w_discard_next;
      if (r_state == REQ) begin
        r_req_pc <= r_pc;
      end
    end
  end

  assign w_wr_entry = '{instr: imem_rdata, pc: r_req_pc};

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wr_entry),
    .pop   (w_pop),
    .flush (redirect_valid),
    .head  (w_head_bits),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head      = fetch_entry_t'(w_head_bits);
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? '0 : w_head.instr;
  assign instr_pc    = w_empty ? '0 : w_head.pc;

endmodule

`default_nettype wire
